// File: rtl/gpio_event_arbiter_pkg.sv
// Shared constants for the GPIO event arbiter: FSM encodings, default event code
// base and gap length, and small helpers used by the arbiter and its picker.
package gpio_event_arbiter_pkg;

  localparam int EVT_W = 8;
  localparam int DEFAULT_NUM_BTN = 4;
  localparam logic [EVT_W-1:0] DEFAULT_CODE_BASE = 8'h30;
  localparam int DEFAULT_GAP_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_GAP     = 2'd2
  } arb_state_t;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [EVT_W-1:0] evt_code(input logic [EVT_W-1:0] base,
                                                input logic [EVT_W-1:0] idx);
    return base + idx;
  endfunction

endpackage

// File: rtl/gpio_event_arbiter_if.sv
// Event byte channel from the arbiter to the UART TX command input (valid/ready).
interface gpio_event_arbiter_if;
  import gpio_event_arbiter_pkg::*;

  logic [EVT_W-1:0] evt_data;
  logic             evt_valid;
  logic             evt_ready;

  modport master (output evt_data, output evt_valid, input evt_ready);
  modport slave  (input evt_data, input evt_valid, output evt_ready);

endinterface

// File: rtl/gpio_event_arbiter_rr_picker.sv
// Round-robin picker: first set request searching upward from ptr+1, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module gpio_event_arbiter_rr_picker #(
  parameter int NUM_BTN = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_BTN-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  assign any = |req;

  // Walk from the farthest candidate back to ptr+1 so the nearest hit wins last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_BTN);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/gpio_event_arbiter.sv
// Captures button press pulses and grants them round-robin as ASCII event bytes.
// Latency: pulse -> pending after 1 edge, evt_valid after 2 edges when idle and enabled.
// Backpressure: byte held stable until evt_ready; then GAP_CYCLES idle edges before next grant.
module gpio_event_arbiter
  import gpio_event_arbiter_pkg::*;
#(
  parameter int               NUM_BTN    = DEFAULT_NUM_BTN,
  parameter logic [EVT_W-1:0] CODE_BASE  = DEFAULT_CODE_BASE,
  parameter int               GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                        src_clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_BTN-1:0]          btn_pulse,
  gpio_event_arbiter_if.master        evt,
  output logic [NUM_BTN-1:0]          pending,
  output logic [NUM_BTN-1:0]          overrun,
  input  logic                        overrun_clr,
  output logic                        busy
);

  localparam int IDX_W = idx_width(NUM_BTN);
  localparam int CNT_W = idx_width(GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_BTN-1:0] pend_q, ovr_q;
  logic [EVT_W-1:0]  data_q;
  logic              valid_q;

  logic [NUM_BTN-1:0] grant_clr;
  logic              load_evt;
  logic              accept;

  logic [NUM_BTN-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  gpio_event_arbiter_rr_picker #(
    .NUM_BTN (NUM_BTN),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req (pend_q),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_clr = '0;
    load_evt  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en && pick_any) begin
          load_evt  = 1'b1;
          grant_clr = pick_gnt;
          ptr_d     = pick_idx;
          state_d   = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // en is deliberately ignored here: an offered byte always completes.
        if (evt.evt_ready) begin
          accept = 1'b1;
          if (GAP_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LOAD;
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(NUM_BTN - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_evt) begin
      data_q  <= evt_code(CODE_BASE, EVT_W'(pick_idx));
      valid_q <= 1'b1;
    end else if (accept) begin
      valid_q <= 1'b0;
    end
  end

  // A press landing on its own grant edge re-arms pending without counting as overrun.
  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      ovr_q  <= '0;
    end else begin
      pend_q <= btn_pulse | (pend_q & ~grant_clr);
      ovr_q  <= (ovr_q & ~{NUM_BTN{overrun_clr}}) | (btn_pulse & pend_q & ~grant_clr);
    end
  end

  assign evt.evt_data  = data_q;
  assign evt.evt_valid = valid_q;
  assign pending       = pend_q;
  assign overrun       = ovr_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_gpio_event_arbiter.sv
// Directed bench for gpio_event_arbiter with a time-based reference model compared every cycle.
module tb_gpio_event_arbiter;

  localparam int NB = 4;
  localparam int GAP = 16;
  localparam logic [7:0] CODE = 8'h30;

  logic          src_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [NB-1:0] btn_pulse = '0;
  logic          overrun_clr = 1'b0;
  logic [NB-1:0] pending;
  logic [NB-1:0] overrun;
  logic          busy;

  gpio_event_arbiter_if evt_if ();

  gpio_event_arbiter #(
    .NUM_BTN    (NB),
    .CODE_BASE  (CODE),
    .GAP_CYCLES (GAP)
  ) dut (
    .src_clk     (src_clk),
    .rst_n       (rst_n),
    .en          (en),
    .btn_pulse   (btn_pulse),
    .evt         (evt_if),
    .pending     (pending),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  always #5 src_clk = ~src_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an offered byte, a pending set, and the edge until which grants are blocked.
  logic [NB-1:0] m_pend = '0;
  logic [NB-1:0] m_ovr = '0;
  logic          m_valid = 1'b0;
  logic [7:0]    m_data = '0;
  int            m_last = NB - 1;
  int            m_cyc = 0;
  int            m_block = 0;

  task automatic model_reset();
    m_pend = '0; m_ovr = '0; m_valid = 1'b0; m_data = '0;
    m_last = NB - 1; m_block = m_cyc;
  endtask

  task automatic model_edge();
    logic [NB-1:0] g;
    int pick;
    g = '0;
    pick = -1;
    m_cyc++;
    if (m_valid) begin
      if (evt_if.evt_ready) begin
        m_valid = 1'b0;
        m_block = m_cyc + GAP;
      end
    end else if (m_cyc > m_block && en && m_pend != 0) begin
      for (int k = 1; k <= NB; k++)
        if (pick < 0 && m_pend[(m_last + k) % NB]) pick = (m_last + k) % NB;
      g[pick] = 1'b1;
      m_last = pick;
      m_valid = 1'b1;
      m_data = CODE + 8'(pick);
    end
    m_ovr  = (overrun_clr ? '0 : m_ovr) | (btn_pulse & m_pend & ~g);
    m_pend = btn_pulse | (m_pend & ~g);
  endtask

  always @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_edge();
  end

  logic [7:0] log_q[$];
  int         log_t[$];

  always @(negedge src_clk) begin
    chk("evt_valid", 32'(evt_if.evt_valid), 32'(m_valid));
    chk("evt_data", 32'(evt_if.evt_data), 32'(m_data));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("busy", 32'(busy), 32'(m_valid || (m_cyc < m_block)));
    if (evt_if.evt_valid && evt_if.evt_ready) begin
      log_q.push_back(evt_if.evt_data);
      log_t.push_back(m_cyc);
    end
  end

  task automatic tick();
    @(posedge src_clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    log_q.delete();
    log_t.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_q.size() < n && k < budget) begin tick(); k++; end
    chk("wait_log_timeout", 32'(log_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || evt_if.evt_valid) && k < budget) begin tick(); k++; end
    chk("wait_idle_timeout", 32'(busy || evt_if.evt_valid), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!evt_if.evt_valid && k < budget) begin tick(); k++; end
    chk("wait_valid_timeout", 32'(evt_if.evt_valid), 32'd1);
  endtask

  task automatic pulse(input logic [NB-1:0] b);
    btn_pulse = b;
    tick();
    btn_pulse = '0;
  endtask

  initial begin
    int base;
    evt_if.evt_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("rst_data", 32'(evt_if.evt_data), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Single press on button 2: latency, code, gap length
    pulse(4'b0100);
    chk("s1_pend_after_e0", 32'(pending), 32'h4);
    chk("s1_valid_after_e0", 32'(evt_if.evt_valid), 32'd0);
    tick();
    chk("s1_valid_after_e1", 32'(evt_if.evt_valid), 32'd1);
    chk("s1_data", 32'(evt_if.evt_data), 32'h32);
    chk("s1_pend_cleared", 32'(pending), 32'd0);
    tick();
    chk("s1_valid_dropped", 32'(evt_if.evt_valid), 32'd0);
    repeat (15) tick();
    chk("s1_busy_gap_end", 32'(busy), 32'd1);
    tick();
    chk("s1_idle_after_gap", 32'(busy), 32'd0);

    // Simultaneous presses from a fresh pointer
    do_reset();
    pulse(4'b1011);
    wait_log(3, 200);
    if (log_q.size() >= 3) begin
      chk("s2_byte0", 32'(log_q[0]), 32'h30);
      chk("s2_byte1", 32'(log_q[1]), 32'h31);
      chk("s2_byte2", 32'(log_q[2]), 32'h33);
      chk("s2_gap01", 32'(log_t[1] - log_t[0] >= 17), 32'd1);
      chk("s2_gap12", 32'(log_t[2] - log_t[1] >= 17), 32'd1);
    end
    chk("s2_overrun", 32'(overrun), 32'd0);
    wait_idle(100);

    // Stall with evt_ready low, re-press during the stall
    evt_if.evt_ready = 1'b0;
    pulse(4'b0010);
    wait_valid(10);
    for (int i = 0; i < 10; i++) begin
      btn_pulse = (i == 3) ? 4'b0010 : 4'b0000;
      tick();
      chk("s3_stall_valid", 32'(evt_if.evt_valid), 32'd1);
      chk("s3_stall_data", 32'(evt_if.evt_data), 32'h31);
    end
    btn_pulse = '0;
    chk("s3_overrun1", 32'(overrun[1]), 32'd0);
    chk("s3_pending1", 32'(pending[1]), 32'd1);
    base = log_q.size();
    evt_if.evt_ready = 1'b1;
    wait_log(base + 2, 200);
    if (log_q.size() >= base + 2) begin
      chk("s3_first", 32'(log_q[base]), 32'h31);
      chk("s3_resend", 32'(log_q[base + 1]), 32'h31);
    end
    wait_idle(100);

    // Enable gating and overrun behaviour
    en = 1'b0;
    pulse(4'b0100);
    tick();
    pulse(4'b0100);
    tick();
    chk("s4_pending2", 32'(pending[2]), 32'd1);
    chk("s4_overrun2", 32'(overrun[2]), 32'd1);
    chk("s4_no_valid", 32'(evt_if.evt_valid), 32'd0);
    base = log_q.size();
    en = 1'b1;
    wait_log(base + 1, 50);
    if (log_q.size() >= base + 1) chk("s4_byte", 32'(log_q[base]), 32'h32);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("s4_clr", 32'(overrun), 32'd0);
    wait_idle(100);
    en = 1'b0;
    pulse(4'b0100);
    btn_pulse = 4'b0100;
    overrun_clr = 1'b1;
    tick();
    btn_pulse = '0;
    overrun_clr = 1'b0;
    chk("s4_set_beats_clr", 32'(overrun), 32'h4);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    base = log_q.size();
    en = 1'b1;
    wait_log(base + 1, 50);
    wait_idle(100);

    // Round-robin fairness after a grant to button 3
    pulse(4'b1000);
    base = log_q.size();
    wait_log(base + 1, 50);
    wait_idle(100);
    en = 1'b0;
    pulse(4'b1001);
    base = log_q.size();
    en = 1'b1;
    wait_log(base + 2, 200);
    if (log_q.size() >= base + 2) begin
      chk("s5_first_btn0", 32'(log_q[base]), 32'h30);
      chk("s5_then_btn3", 32'(log_q[base + 1]), 32'h33);
    end
    wait_idle(100);

    // Asynchronous reset while a byte is being offered
    evt_if.evt_ready = 1'b0;
    pulse(4'b0110);
    wait_valid(10);
    tick();
    rst_n = 1'b0;
    #1;
    chk("s6_async_valid", 32'(evt_if.evt_valid), 32'd0);
    chk("s6_async_pending", 32'(pending), 32'd0);
    chk("s6_async_busy", 32'(busy), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    evt_if.evt_ready = 1'b1;
    base = log_q.size();
    repeat (40) tick();
    chk("s6_no_spurious", 32'(log_q.size()), 32'(base));
    chk("s6_valid_low", 32'(evt_if.evt_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_event_arbiter.md
Name: gpio_event_arbiter

Overview:
- Collects single-cycle press pulses from several debounced push-buttons and shares one UART TX byte channel between them.
- Latches each press as pending and grants pending buttons in round-robin order.
- Emits one ASCII event code per grant on a valid/ready handshake, then enforces a minimum inter-event gap.
- Sits between the per-button debounce instances and the UART transmitter command input.

Parameters:
- NUM_BTN, 4: number of button inputs, 2..8.
- CODE_BASE, 8'h30: event byte for button i is CODE_BASE + i (ASCII '0'..).
- GAP_CYCLES, 16: idle src_clk cycles enforced after each accepted byte; 0 means no gap.

Ports:
- src_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  grant enable; when low, no new grants are made but captures continue.
- btn_pulse  in  NUM_BTN  one-cycle press pulses from the debounce blocks.
- evt_data  out  8  event byte to the UART TX.
- evt_valid  out  1  evt_data is valid.
- evt_ready  in  1  UART TX accepts the byte when evt_valid and evt_ready are both high at an edge.
- pending  out  NUM_BTN  captured presses not yet granted.
- overrun  out  NUM_BTN  sticky flag: a press arrived while that button was already pending.
- overrun_clr  in  1  clears all overrun bits.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - evt_valid=0, evt_data=0, pending=0, overrun=0, busy=0.
  - FSM=IDLE, gap counter=0, rr pointer=NUM_BTN-1 (button 0 has first priority).
- Capture, every edge, per bit i:
  - pending[i] <= btn_pulse[i] | (pending[i] & ~grant_clr[i]).
  - If btn_pulse[i] & pending[i] & ~grant_clr[i], set overrun[i].
  - A pulse on the same edge the bit is granted leaves pending[i]=1 with no overrun.
- Overrun clear: overrun_clr clears all overrun bits. A set condition on the same edge wins for that bit.
- FSM states: IDLE, PRESENT, GAP.
- IDLE: if en and pending is nonzero, at the edge:
  - Select idx = first set bit searching from rr pointer+1, wrapping modulo NUM_BTN.
  - evt_data <= CODE_BASE+idx (8-bit, wraps mod 256); evt_valid <= 1; grant_clr[idx]=1; rr pointer <= idx; go to PRESENT.
- PRESENT:
  - evt_data and evt_valid are held stable while evt_ready=0.
  - On an edge with evt_ready=1: evt_valid <= 0. If GAP_CYCLES=0, go to IDLE; otherwise load the counter with GAP_CYCLES-1 and go to GAP.
  - Dropping en does not abort an in-flight byte.
- GAP:
  - Counter decrements each edge; at 0, go to IDLE.
  - No grants are made during GAP; captures continue.
- Latency:
  - A pulse sampled at edge E0 gives pending=1 after E0.
  - evt_valid is high after E1 (with FSM in IDLE and en=1).
  - After acceptance at edge A, the earliest next evt_valid is after edge A+GAP_CYCLES+1.
- busy = (FSM != IDLE), registered-state decode.
- Simultaneous pulses on several buttons: all captured on the same edge and granted in rr order, one per handshake.
- Reset asserted mid-PRESENT: evt_valid drops immediately (asynchronously) and pending presses are lost.

Decomposition:
- Shared constants header alongside the existing config macros holds the FSM state encodings (IDLE=2'd0, PRESENT=2'd1, GAP=2'd2) and the default CODE_BASE/GAP_CYCLES.
- One sub-module, rr_picker: combinational.
  - Inputs: req[NUM_BTN], ptr.
  - Outputs: gnt one-hot and idx; any = |req.
  - Search starts at ptr+1 and wraps.
- Capture, FSM, gap counter and overrun logic stay in gpio_event_arbiter.

Test Plan:
- Reset, then btn_pulse=4'b0100 for one cycle with evt_ready=1 and en=1 -> evt_valid high two edges after the pulse with evt_data=8'h32; it drops after one accepted edge; busy stays high for 16 further edges; pending=0.
- btn_pulse=4'b1011 on one cycle with evt_ready=1 -> bytes 8'h30, 8'h31, 8'h33 in that order, each separated by at least 17 edges; overrun stays 0.
- evt_ready=0 for 10 cycles after evt_valid rises on btn1 -> evt_data=8'h31 stays stable and evt_valid stays high for all 10 cycles; a second btn1 pulse during the stall sets overrun[1]=0 and pending[1]=1, and 8'h31 is sent again after the gap.
- Two btn2 pulses while en=0 -> pending[2]=1, overrun[2]=1, no evt_valid. Raise en -> one 8'h32. Pulse overrun_clr -> overrun=0; an overrun_clr coincident with a new overrun -> overrun[2] remains 1.
- Round-robin fairness: after granting btn3, hold btn0 and btn3 pending together -> btn0 is granted before btn3.
- rst_n low while evt_valid=1 -> evt_valid=0 and pending=0 immediately, before the next clock edge; after release, no spurious byte is sent.
